// File: rtl/multi_dataflow_engine_kernel.sv
// Engine-side join kernel: three operand streams in, one result stream out.
// Two-stage stall-all pipeline with a selectable arithmetic op per job.
module multi_dataflow_engine_kernel #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    start_i,
   input  logic [CNT_WIDTH-1:0]    len_i,
   input  logic [1:0]              op_i,
   input  logic [DATA_WIDTH-1:0]   in0_data_i,
   input  logic [DATA_WIDTH-1:0]   in1_data_i,
   input  logic [DATA_WIDTH-1:0]   in2_data_i,
   input  logic                    in0_valid_i,
   input  logic                    in1_valid_i,
   input  logic                    in2_valid_i,
   output logic                    in0_ready_o,
   output logic                    in1_ready_o,
   output logic                    in2_ready_o,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic [DATA_WIDTH/8-1:0] out_strb_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic [CNT_WIDTH-1:0]    cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_ADD3 = 2'b00;
   localparam logic [1:0] OP_MAC  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MAX3 = 2'b11;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE =
      {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic [CNT_WIDTH-1:0]  r_len;
   logic [1:0]            r_op;
   logic [CNT_WIDTH-1:0]  r_in_cnt;
   logic [CNT_WIDTH-1:0]  r_out_cnt;

   logic                  r_v1;
   logic [DATA_WIDTH-1:0] r_p1;
   logic [DATA_WIDTH-1:0] r_c1;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;

   logic                  w_adv;
   logic                  w_all_valid;
   logic                  w_room;
   logic                  w_fire;
   logic                  w_out_hs;
   logic                  w_last;
   logic                  w_is_mac;
   logic                  w_is_sub;
   logic                  w_is_max;
   logic [DATA_WIDTH-1:0] w_mul;
   logic [DATA_WIDTH-1:0] w_p1;
   logic [DATA_WIDTH-1:0] w_res;

   // Stall-all advance, join condition and output handshake.
   assign w_adv       = enable_i & (~r_out_valid | out_ready_i);
   assign w_all_valid = in0_valid_i & in1_valid_i & in2_valid_i;
   assign w_room      = (r_in_cnt < r_len);
   assign w_fire      = (r_state == ST_RUN) & w_room
                      & w_all_valid & w_adv;
   assign w_out_hs    = r_out_valid & out_ready_i & enable_i;
   assign w_last      = ((r_out_cnt + CNT_ONE) == r_len);

   // Op decode from the job-latched op (ADD3 is the fallback).
   assign w_is_mac = (r_op == OP_MAC);
   assign w_is_sub = (r_op == OP_SUB);
   assign w_is_max = (r_op == OP_MAX3);

   assign w_mul = in0_data_i * in1_data_i;

   // Stage 1 operator on a/b.
   always_comb begin
      w_p1 = in0_data_i + in1_data_i;
      unique case (1'b1)
         w_is_mac: w_p1 = w_mul;
         w_is_sub: w_p1 = in0_data_i - in1_data_i;
         w_is_max: w_p1 = ($signed(in0_data_i) > $signed(in1_data_i))
                        ? in0_data_i : in1_data_i;
         default:  w_p1 = in0_data_i + in1_data_i;
      endcase
   end

   // Stage 2 combine of the partial result with c.
   always_comb begin
      w_res = r_p1 + r_c1;
      unique case (1'b1)
         w_is_sub: w_res = r_p1 - r_c1;
         w_is_max: w_res = ($signed(r_p1) > $signed(r_c1))
                         ? r_p1 : r_c1;
         default:  w_res = r_p1 + r_c1;
      endcase
   end

   // Pipeline registers; everything moves together on adv.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_v1        <= 1'b0;
         r_p1        <= '0;
         r_c1        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (clear_i) begin
         r_v1        <= 1'b0;
         r_p1        <= '0;
         r_c1        <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_adv) begin
         r_v1        <= w_fire;
         r_p1        <= w_p1;
         r_c1        <= in2_data_i;
         r_out_valid <= r_v1;
         r_out_data  <= r_v1 ? w_res : '0;
      end
   end

   // Job FSM with element counters and registered status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_len     <= '0;
         r_op      <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else if (clear_i) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_len     <= '0;
         r_op      <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_fire) begin
            r_in_cnt <= r_in_cnt + CNT_ONE;
         end
         if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + CNT_ONE;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (start_i && enable_i) begin
                  r_len     <= len_i;
                  r_op      <= op_i;
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
                  if (len_i != '0) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_out_hs && w_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign in0_ready_o = w_fire;
   assign in1_ready_o = w_fire;
   assign in2_ready_o = w_fire;

   assign out_data_o  = r_out_data;
   assign out_valid_o = r_out_valid;
   assign out_strb_o  = {(DATA_WIDTH/8){r_out_valid}};
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign cnt_o       = r_out_cnt;

endmodule

// File: tb/tb_multi_dataflow_engine_kernel.sv
// Scoreboard bench for multi_dataflow_engine_kernel.
// Source queues feed the join; a monitor pops expected results.
module tb_multi_dataflow_engine_kernel;

   localparam int DW = 32;
   localparam int CW = 16;

   localparam logic [1:0] OP_ADD3 = 2'b00;
   localparam logic [1:0] OP_MAC  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MAX3 = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          enable;
   logic          start;
   logic [CW-1:0] len;
   logic [1:0]    op;
   logic [DW-1:0] d0, d1, d2;
   logic          v0, v1, v2;
   logic          r0, r1, r2;
   logic [DW-1:0] odata;
   logic [3:0]    ostrb;
   logic          ovalid;
   logic          oready;
   logic          busy;
   logic          done;
   logic [CW-1:0] cnt;

   multi_dataflow_engine_kernel #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear),
      .enable_i   (enable),
      .start_i    (start),
      .len_i      (len),
      .op_i       (op),
      .in0_data_i (d0),
      .in1_data_i (d1),
      .in2_data_i (d2),
      .in0_valid_i(v0),
      .in1_valid_i(v1),
      .in2_valid_i(v2),
      .in0_ready_o(r0),
      .in1_ready_o(r1),
      .in2_ready_o(r2),
      .out_data_o (odata),
      .out_strb_o (ostrb),
      .out_valid_o(ovalid),
      .out_ready_i(oready),
      .busy_o     (busy),
      .done_o     (done),
      .cnt_o      (cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] src_a[$];
   logic [DW-1:0] src_b[$];
   logic [DW-1:0] src_c[$];
   logic [DW-1:0] exp_q[$];

   int gap      = 0;
   bit bp       = 1'b0;
   int cyc      = 0;
   int n_fire   = 0;
   int n_out    = 0;
   int done_cnt = 0;
   int fire_cyc = 0;
   int out_cyc  = 0;
   int done_cyc = 0;
   int st_cyc   = 0;
   bit stall_prev = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, need 0x%08h", nm, act, expv);
      end
   endtask

   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] e,
                       input bit has_exp);
      src_a.push_back(a);
      src_b.push_back(b);
      src_c.push_back(c);
      if (has_exp) exp_q.push_back(e);
   endtask

   task automatic flush_all();
      src_a.delete();
      src_b.delete();
      src_c.delete();
      exp_q.delete();
   endtask

   // Upstream FIFO model: pops one element per observed join.
   initial begin
      bit fired;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
      d0 = '0; d1 = '0; d2 = '0;
      forever begin
         @(negedge clk);
         fired = v0 & v1 & v2 & r0;
         @(posedge clk);
         #1;
         if (fired && src_a.size() > 0) begin
            void'(src_a.pop_front());
            void'(src_b.pop_front());
            void'(src_c.pop_front());
         end
         if (src_a.size() > 0) begin
            d0 = src_a[0]; d1 = src_b[0]; d2 = src_c[0];
            v1 = 1'b1; v2 = 1'b1;
            if (gap > 0) begin
               v0 = 1'b0;
               gap--;
            end else begin
               v0 = 1'b1;
            end
         end else begin
            v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
         end
      end
   end

   // Downstream ready: always ready, or random in back-pressure mode.
   initial begin
      oready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         oready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: join legality, strobe, hold stability, scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            chk("join", 32'({r0, r1, r2, r0 & ~(v0 & v1 & v2)}),
                32'({r0, r0, r0, 1'b0}));
            chk("strb", 32'(ostrb), 32'({4{ovalid}}));
            if (stall_prev) begin
               chk("hold_valid", 32'(ovalid), 32'd1);
               chk("hold_data", odata, prev_data);
            end
            if (r0) begin
               n_fire++;
               fire_cyc = cyc;
            end
            if (ovalid && oready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL extra_out: got 0x%08h, need none", odata);
               end else begin
                  chk("data", odata, exp_q.pop_front());
               end
               n_out++;
               out_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            stall_prev = ovalid & ~oready;
            prev_data  = odata;
         end
      end
   end

   task automatic start_job(input logic [1:0] o, input logic [CW-1:0] l);
      @(posedge clk);
      #1;
      start  = 1'b1;
      len    = l;
      op     = o;
      st_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input string nm);
      int k;
      k = 0;
      while (done_cnt == base && k < 500) begin
         @(posedge clk);
         k++;
      end
      n_tests++;
      if (done_cnt == base) begin
         n_fail++;
         $display("FAIL %s_timeout: got no done, need done", nm);
      end
   endtask

   task automatic run_job(input logic [1:0] o, input logic [CW-1:0] l,
                          input string nm);
      int base;
      base = done_cnt;
      start_job(o, l);
      wait_done(base, nm);
      repeat (3) @(posedge clk);
      #2;
      chk({nm, "_cnt"}, 32'(cnt), 32'(l));
      chk({nm, "_pulses"}, done_cnt - base, 1);
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      int f0;
      int n0;
      int k;
      int base;
      #50000;
      $display("FAIL watchdog: got no finish, need finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      int n0;
      int k;
      int base;
      rst = 1'b1; clear = 1'b0; enable = 1'b1;
      start = 1'b0; len = '0; op = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_data", odata, 32'd0);
      chk("rst_valid", 32'(ovalid), 32'd0);
      chk("rst_strb", 32'(ostrb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // MAC single element with latency checks
      push(32'd3, 32'd5, 32'd7, 32'd22, 1'b1);
      f0 = n_fire;
      run_job(OP_MAC, 16'd1, "mac1");
      chk("mac1_fires", n_fire - f0, 1);
      chk("mac1_lat", out_cyc - fire_cyc, 2);
      chk("mac1_done_lat", done_cyc - fire_cyc, 3);

      // ADD3 wrap
      push(32'hFFFF_FFFF, 32'd1, 32'd2, 32'd2, 1'b1);
      run_job(OP_ADD3, 16'd1, "add_wrap");

      // SUB, including wrap below zero
      push(32'd10, 32'd3, 32'd2, 32'd5, 1'b1);
      push(32'd0, 32'd1, 32'd1, 32'hFFFF_FFFE, 1'b1);
      run_job(OP_SUB, 16'd2, "sub");

      // MAX3 signed
      push(32'd10, 32'd3, 32'd2, 32'd10, 1'b1);
      push(32'hFFFF_FFFC, 32'hFFFF_FFF7, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 1'b1);
      push(32'hFFFF_FFF9, 32'd2, 32'd1, 32'd2, 1'b1);
      run_job(OP_MAX3, 16'd3, "max3");

      // MAC low-word product
      push(32'h0001_0000, 32'h0001_0001, 32'd5, 32'h0001_0005, 1'b1);
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
      run_job(OP_MAC, 16'd2, "mac2");

      // Back-pressure, in0 gap, ignored start, surplus element
      bp = 1'b1;
      for (int i = 0; i < 8; i++)
         push(32'(100 + i), 32'd20, 32'(i), 32'(120 + 2 * i), 1'b1);
      push(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      base = done_cnt;
      start_job(OP_ADD3, 16'd8);
      k = 0;
      while (src_a.size() > 6 && k < 200) begin
         @(posedge clk);
         k++;
      end
      gap = 3;
      @(posedge clk);
      #1;
      start = 1'b1; len = 16'd1; op = OP_MAX3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(base, "bp");
      bp = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("bp_cnt", 32'(cnt), 32'd8);
      chk("bp_pulses", done_cnt - base, 1);
      chk("bp_drain", exp_q.size(), 0);
      chk("bp_surplus", src_a.size(), 1);
      flush_all();
      repeat (2) @(posedge clk);

      // Zero-length job
      push(32'd1, 32'd2, 32'd3, 32'd0, 1'b0);
      f0 = n_fire;
      run_job(OP_ADD3, 16'd0, "len0");
      chk("len0_lat", done_cyc - st_cyc, 1);
      chk("len0_fires", n_fire - f0, 0);
      chk("len0_left", src_a.size(), 1);
      flush_all();
      repeat (2) @(posedge clk);

      // Reset in the middle of a job
      for (int i = 1; i <= 5; i++)
         push(32'(i), 32'd2, 32'd3, 32'(i + 5), 1'b1);
      n0 = n_out;
      start_job(OP_ADD3, 16'd5);
      k = 0;
      while (n_out < n0 + 2 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("mid_outs", n_out - n0, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_data", odata, 32'd0);
      chk("arst_valid", 32'(ovalid), 32'd0);
      chk("arst_strb", 32'(ostrb), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_cnt", 32'(cnt), 32'd0);
      chk("arst_ready", 32'({r0, r1, r2}), 32'd0);
      flush_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      push(32'd7, 32'd8, 32'd9, 32'd24, 1'b1);
      push(32'd1, 32'd2, 32'd3, 32'd6, 1'b1);
      run_job(OP_ADD3, 16'd2, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_dataflow_engine_kernel.md
Name: multi_dataflow_engine_kernel

Overview:
Engine-side compute kernel directly downstream of the streamer's engine-side FIFOs. It joins the three 32-bit input streams (inStream0..2) element by element and applies a selectable arithmetic op in a 2-stage stall-all pipeline. It emits results on outStream0, which the streamer stores back to TCDM. Job length, op select and start come from the control slave; busy/done/count flags return to it.

Parameters:
DATA_WIDTH, 32, width of every stream data bus
CNT_WIDTH, 16, width of job length and element counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear, same effect as reset
enable_i  in  1  local enable; low freezes all state
start_i  in  1  one-cycle job start pulse
len_i  in  CNT_WIDTH  number of elements in the job, sampled on start
op_i  in  2  op select, sampled on start
in0_data_i / in1_data_i / in2_data_i  in  DATA_WIDTH  operands a / b / c
in0_valid_i / in1_valid_i / in2_valid_i  in  1  operand valid
in0_ready_o / in1_ready_o / in2_ready_o  out  1  operand ready
out_data_o  out  DATA_WIDTH  result
out_strb_o  out  DATA_WIDTH/8  byte strobe, all ones while out_valid_o is high, else 0
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
busy_o  out  1  job in progress
done_o  out  1  one-cycle end-of-job pulse
cnt_o  out  CNT_WIDTH  results emitted in the current job

Behaviour:
- Reset (rst_i high, async) or clear_i (sync): FSM=IDLE; counters, pipeline valids and the len/op registers cleared. All outputs 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start_i & enable_i with len_i!=0. len and op are latched at this edge; in_cnt and out_cnt are zeroed.
  - IDLE->DONE on start_i with len_i==0. Nothing is consumed.
  - RUN->DONE on the cycle an output handshake makes out_cnt equal to len.
  - DONE->IDLE unconditionally.
  - start_i outside IDLE is ignored.
- busy_o = (state==RUN). done_o = (state==DONE), a one-cycle registered pulse.
- adv = enable_i & (!out_valid_o | out_ready_i). All pipeline stages shift only when adv is high.
- Join: fire = state==RUN & in_cnt<len & in0_valid & in1_valid & in2_valid & adv.
  - inX_ready_o = fire, i.e. all three readies are asserted together, never partially.
  - Ready may depend on valid. Inputs are never consumed unless all three are valid.
- Stage 1 (registered on adv): v1<=fire; p1 <= op-dependent value; c1<=c.
  - op 00 (ADD3): p1 = a+b
  - op 01 (MAC): p1 = low DATA_WIDTH bits of a*b (unsigned)
  - op 10 (SUB): p1 = a-b
  - op 11 (MAX3): p1 = signed max(a,b)
- Stage 2 / output register (on adv): out_valid_o<=v1; out_data_o <= combine(p1, c1).
  - ADD3 and MAC: p1+c1
  - SUB: p1-c1
  - MAX3: signed max(p1,c1)
- All arithmetic wraps modulo 2^DATA_WIDTH. No saturation, no overflow flag.
- Latency: an element joined at edge T is visible on out_data_o/out_valid_o after edge T+2, provided adv stays high. Throughput is 1 element/cycle while out_ready_i is high.
- Output hold: while out_valid_o & !out_ready_i, out_data_o and out_valid_o are held stable and no inputs are accepted.
- Counters:
  - in_cnt++ on fire.
  - out_cnt++ on out_valid_o & out_ready_i & enable_i.
  - cnt_o = out_cnt; it holds its final value through DONE and IDLE until the next start.
- Elements offered beyond len stay unconsumed (ready 0).
- enable_i low: no fire, no shift, no counter change. out_valid_o and out_data_o are held. FSM does not advance except DONE->IDLE.
- Reset mid-job: the job is aborted immediately. In-flight pipeline data is discarded and the upstream FIFO contents are untouched.

Test Plan:
- MAC, len=1, a=3 b=5 c=7 all valid at T, out_ready=1 -> inX_ready=1 at T only; out_data=22, strb=0xF, valid at T+2; done_o pulse at T+3; cnt_o=1.
- ADD3 wrap, len=1, a=0xFFFFFFFF b=1 c=2 -> out_data=0x00000002.
- SUB then MAX3 (separate jobs), a=10 b=3 c=2 -> 5. MAX3 with a=-4 b=-9 c=-1 -> 0xFFFFFFFF.
- Back-pressure, ADD3, len=8, random out_ready -> all 8 results emitted in order with data stable while stalled. in0 valid missing for 3 cycles -> no ready on any input during those cycles. cnt_o=8, exactly one done pulse.
- len=0 start -> done_o one cycle later, no inX_ready ever high; start_i during RUN -> ignored.
- rst_i asserted mid-job after 2 of 5 outputs -> all outputs 0 asynchronously. A new job with len=2 then completes correctly with cnt_o=2.
